// File: rtl/hazard_sched.sv
// hazard_sched
// ------------
// Issue controller for the decode stage of a 5-stage in-order pipeline.
// It sits between the IF/ID and ID/EX latches. A 16-entry scoreboard
// tracks register writes that are in flight. There is no forwarding, so
// any RAW or WAW dependency on a busy register holds ID until the writer
// retires. A taken branch that issues from ID starts a wrong-path flush.
// The flush kills IF and suppresses issue for FLUSH_CYCLES cycles. The
// block also counts total stall cycles and raises a sticky watchdog error
// when one stall run becomes too long.
//
// Parameters
//   FLUSH_CYCLES : cycles of issue suppression / IF kill after a taken branch (1..7)
//   MAX_STALL    : consecutive stall cycles that set stall_err (1..65535)
//   ZERO_REG_EN  : 1 = register 0 is never marked busy
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   id_valid            : ID holds a real instruction
//   id_ra/id_rb/id_rd   : source A, source B and destination register numbers
//   id_uses_ra/_rb      : the instruction reads ra / rb
//   id_writes           : the instruction writes rd
//   id_branch           : the instruction is a branch
//   pc_select           : branch compare is taken, valid in the same cycle
//   wb_valid, wb_rd     : writeback retiring a write to wb_rd this cycle
//   issue               : ID instruction advances to EX this cycle
//   stall_id            : hold PC and the IF/ID latch
//   bubble_ex           : load a NOP into ID/EX
//   flush_if            : clear the IF/ID latch at the next edge
//   busy_mask           : scoreboard, bit n = write to rn pending (registered)
//   stall_count         : saturating total of stall cycles since reset (registered)
//   stall_err           : sticky watchdog error (registered)

module hazard_sched #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 64,
  parameter bit          ZERO_REG_EN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_ra,
  input  logic [3:0]  id_rb,
  input  logic [3:0]  id_rd,
  input  logic        id_uses_ra,
  input  logic        id_uses_rb,
  input  logic        id_writes,
  input  logic        id_branch,
  input  logic        pc_select,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  output logic        issue,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_if,
  output logic [15:0] busy_mask,
  output logic [15:0] stall_count,
  output logic        stall_err
);

  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [15:0] STALL_LIM  = 16'(MAX_STALL);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t      state;
  logic [2:0]  flush_cnt;
  logic [15:0] consec_cnt;
  logic        hazard;
  logic [15:0] busy_next;

  // Hazard check against the registered scoreboard only. A register that
  // retires this cycle still counts as busy, because the register file is
  // not assumed to write before it reads. The value becomes readable in
  // the cycle after writeback.
  always_comb begin
    hazard = id_valid &
             ((id_uses_ra & busy_mask[id_ra]) |
              (id_uses_rb & busy_mask[id_rb]) |
              (id_writes  & busy_mask[id_rd]));
  end

  // Pipeline control outputs. In RUN, ID issues unless a hazard holds it.
  // A branch redirects only on the cycle it actually issues. A stalled
  // branch's pc_select is ignored. In FLUSH, the wrong-path slots are
  // killed: IF is cleared, EX gets bubbles and the ID inputs are ignored.
  always_comb begin
    issue     = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b1;
    flush_if  = 1'b0;
    if (state == ST_RUN) begin
      issue     = id_valid & ~hazard;
      stall_id  = hazard;
      bubble_ex = ~(id_valid & ~hazard);
      flush_if  = id_valid & ~hazard & id_branch & pc_select;
    end else begin
      flush_if  = 1'b1;
    end
  end

  // Next scoreboard value. The writeback clear is applied first and the
  // new issue's set second. When both hit the same register, the bit stays
  // set: the newly issued write is still pending. Clearing a register that
  // is not busy leaves the mask unchanged.
  always_comb begin
    busy_next = busy_mask;
    if (wb_valid) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (issue && id_writes) begin
      busy_next[id_rd] = 1'b1;
    end
    if (ZERO_REG_EN) begin
      busy_next[0] = 1'b0;
    end
  end

  // Flush sequencer. The edge that sees flush_if in RUN loads the counter
  // with FLUSH_CYCLES. The block returns to RUN on the edge where the
  // counter reads 1. FLUSH therefore occupies exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush_if) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt <= 3'd1) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask <= 16'h0000;
    end else begin
      busy_mask <= busy_next;
    end
  end

  // Stall accounting. The total count saturates at 0xFFFF. The run-length
  // counter measures consecutive stall cycles and clears on any non-stall
  // cycle, and FLUSH cycles are not stalls. The run-length counter stops at
  // the limit so it never wraps. The watchdog sets on the edge where the
  // run length reaches MAX_STALL, and it stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'h0000;
      consec_cnt  <= 16'h0000;
      stall_err   <= 1'b0;
    end else begin
      if (stall_id) begin
        if (stall_count != 16'hFFFF) begin
          stall_count <= stall_count + 16'd1;
        end
        if (consec_cnt != STALL_LIM) begin
          consec_cnt <= consec_cnt + 16'd1;
        end
        if (({1'b0, consec_cnt} + 17'd1) >= {1'b0, STALL_LIM}) begin
          stall_err <= 1'b1;
        end
      end else begin
        consec_cnt <= 16'h0000;
      end
    end
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Issue controller for the decode stage of the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Sits between the IF/ID latch and the ID/EX latch.
- Tracks in-flight register writes in a 16-entry scoreboard and stalls ID on RAW/WAW hazards (no forwarding exists).
- Sequences the wrong-path flush after a branch taken in ID, counts stall cycles and raises a sticky watchdog error on excessive stalls.

Parameters:
FLUSH_CYCLES, 1, cycles issue is suppressed and IF killed after a taken branch issues (1..7)
MAX_STALL, 64, consecutive stall cycles after which stall_err sets (1..65535)
ZERO_REG_EN, 0, 1 = register 0 is never marked busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_ra  in  4  source register A
id_rb  in  4  source register B
id_rd  in  4  destination register
id_uses_ra  in  1  instruction reads ra
id_uses_rb  in  1  instruction reads rb
id_writes  in  1  instruction writes rd
id_branch  in  1  instruction is a branch
pc_select  in  1  branch compare taken (branch AND equal), valid same cycle
wb_valid  in  1  writeback retiring this cycle
wb_rd  in  4  register written by WB
issue  out  1  ID instruction advances to EX this cycle
stall_id  out  1  hold PC and IF/ID latch
bubble_ex  out  1  load NOP into ID/EX
flush_if  out  1  clear IF/ID latch at next edge
busy_mask  out  16  scoreboard, bit n = write to rn pending
stall_count  out  16  saturating total stall cycles since reset
stall_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, any time, mid-flush or mid-stall included) has the following effects:
  - busy_mask=0, stall_count=0, stall_err=0.
  - Internal consecutive-stall counter=0, flush counter=0, state=RUN.
  - Combinational outputs then follow state RUN.
- States are RUN, FLUSH.
- hazard (combinational, registered busy only) = id_valid AND (uses_ra&busy[ra] OR uses_rb&busy[rb] OR writes&busy[rd]).
  - A register retiring this cycle still counts as busy; it is readable the next cycle (regfile write-before-read not assumed).
- RUN outputs:
  - issue = id_valid & ~hazard.
  - stall_id = hazard.
  - bubble_ex = ~issue.
  - flush_if = issue & id_branch & pc_select.
  - pc_select is ignored unless issue=1; a stalled branch never redirects.
- RUN to FLUSH transition: at the edge where flush_if=1, enter FLUSH and load flush counter=FLUSH_CYCLES.
- FLUSH outputs:
  - issue=0, stall_id=0, bubble_ex=1, flush_if=1.
  - id inputs are ignored.
  - The counter decrements each cycle; when it reaches 1, return to RUN at the next edge.
  - FLUSH therefore lasts exactly FLUSH_CYCLES cycles.
- Scoreboard update each edge, applied in order:
  - clear bit wb_rd if wb_valid.
  - then set bit id_rd if issue & id_writes.
  - Set and clear of the same register in the same cycle: set wins (bit stays 1).
  - With ZERO_REG_EN=1, bit 0 is forced to 0.
  - wb_valid on a non-busy register has no effect.
- Stall accounting:
  - Each cycle with stall_id=1, stall_count increments and saturates at 0xFFFF.
  - The consecutive counter increments on stall_id=1 and clears on stall_id=0.
  - When the consecutive counter reaches MAX_STALL, stall_err sets and stays set until rst.
  - FLUSH cycles are not stalls.
- Latency:
  - Hazard detection is combinational, 0 cycles.
  - Scoreboard changes are visible the cycle after the edge.
- All outputs except issue, stall_id, bubble_ex and flush_if are direct register outputs.

Test Plan:
1. Reset, then issue writer rd=3, nothing retiring -> next cycle busy_mask=0x0008; a reader with ra=3 gets issue=0, stall_id=1, bubble_ex=1, and stall_count increments to 1.
2. With r3 busy, assert wb_valid wb_rd=3 while the dependent instruction waits -> stall held that cycle; next cycle busy_mask=0x0000 and issue=1.
3. Same cycle: wb_valid wb_rd=5 and issuing writer id_rd=5 -> busy[5] remains 1; with wb_rd=5 and id_rd=6 -> busy_mask=0x0040.
4. FLUSH_CYCLES=2, branch with pc_select=1, no hazard -> issue=1 and flush_if=1 on cycle 0; cycles 1-2 have flush_if=1, issue=0, bubble_ex=1; cycle 3 is RUN.
5. Branch with busy source and pc_select=1 -> no flush_if, state stays RUN, until the source retires; flush happens only on the issue cycle.
6. MAX_STALL=4, hold a hazard 4 cycles -> stall_err=1 after the 4th edge and stays 1 after the hazard clears; async rst mid-FLUSH -> all outputs at reset values immediately, without waiting for a clock edge.
